// File: rtl/div_pkg.sv
// Shared definitions for the Goldschmidt divider: controller states,
// datapath multiplicand-select encodings and the default operand width.
package div_pkg;

    localparam int DIV_WIDTH = 16;

    // Controller sequencing states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT_D  = 3'd1,
        INIT_N  = 3'd2,
        ITER_D  = 3'd3,
        ITER_N  = 3'd4,
        CAPTURE = 3'd5
    } state_t;

    // sel_ND_mux encodings: which pair the datapath multiplier uses
    localparam logic [1:0] SEL_IA_D = 2'b00;
    localparam logic [1:0] SEL_IA_N = 2'b01;
    localparam logic [1:0] SEL_K_D  = 2'b10;
    localparam logic [1:0] SEL_K_N  = 2'b11;

endpackage : div_pkg

// File: rtl/goldschmidt_ctrl.sv
// Sequencing controller for the Goldschmidt divider datapath. Latches one
// request, walks the datapath through the initial IA products and ITERS
// K-refinement pairs, then captures the datapath result as the quotient.
// All control outputs are decoded from the registered state only.
module goldschmidt_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int ITERS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] n_in,
    input  logic [WIDTH-1:0] d_in,
    input  logic [WIDTH-1:0] ia_in,
    input  logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] N,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] IA,
    output logic             load_regN,
    output logic             load_regD,
    output logic [1:0]       sel_ND_mux,
    output logic             sel_K_mux,
    output logic             busy,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    localparam int CW = $clog2(ITERS + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);

    // A schedule with no refinement pass is meaningless; reject it early.
    generate
        if (ITERS < 1) begin : g_bad_iters
            $error("goldschmidt_ctrl: ITERS must be at least 1");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CW-1:0]    iter_cnt_q, iter_cnt_d;
    logic [WIDTH-1:0] n_q, d_q, ia_q, q_q;
    logic             q_valid_q;

    // Next-state logic: linear schedule with one loop over the K pairs.
    always_comb begin
        state_d    = state_q;
        iter_cnt_d = iter_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = INIT_D;
                    iter_cnt_d = '0;
                end
            end
            INIT_D:  state_d = INIT_N;
            INIT_N:  state_d = ITER_D;
            ITER_D:  state_d = ITER_N;
            ITER_N: begin
                iter_cnt_d = iter_cnt_q + CW'(1);
                if (iter_cnt_q == LAST_ITER) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = ITER_D;
                end
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore decode of datapath controls; IDLE and CAPTURE leave them inactive.
    always_comb begin
        load_regN  = 1'b0;
        load_regD  = 1'b0;
        sel_ND_mux = SEL_IA_D;
        sel_K_mux  = 1'b0;
        case (state_q)
            INIT_D: begin
                load_regD  = 1'b1;
                sel_ND_mux = SEL_IA_D;
                sel_K_mux  = 1'b1;
            end
            INIT_N: begin
                load_regN  = 1'b1;
                sel_ND_mux = SEL_IA_N;
                sel_K_mux  = 1'b1;
            end
            ITER_D: begin
                load_regD  = 1'b1;
                sel_ND_mux = SEL_K_D;
            end
            ITER_N: begin
                load_regN  = 1'b1;
                sel_ND_mux = SEL_K_N;
            end
            default: begin
                load_regN  = 1'b0;
            end
        endcase
    end

    // State, counter, operand hold and quotient capture registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            iter_cnt_q <= '0;
            n_q        <= '0;
            d_q        <= '0;
            ia_q       <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
            // Operands change only on an accept, so they stay stable for
            // the whole divide and until the next request is taken.
            if (state_q == IDLE && start) begin
                n_q  <= n_in;
                d_q  <= d_in;
                ia_q <= ia_in;
            end
            if (state_q == CAPTURE) begin
                q_q <= result;
            end
            q_valid_q <= (state_q == CAPTURE);
        end
    end

    assign busy    = (state_q != IDLE);
    assign N       = n_q;
    assign D       = d_q;
    assign IA      = ia_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;

endmodule : goldschmidt_ctrl

// File: tb/tb_goldschmidt_ctrl.sv
// Directed bench for goldschmidt_ctrl: a cycle-count reference tracks where
// each request is in its schedule, and expected quotients are queued at the
// accept edge and retired when q_valid is expected.
module tb_goldschmidt_ctrl;

    localparam int W     = 16;
    localparam int ITERS = 4;
    localparam int LAST  = 2 * ITERS + 3;   // CAPTURE cycle index

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] n_in, d_in, ia_in;
    logic [W-1:0] result;
    logic [W-1:0] N, D, IA;
    logic         load_regN, load_regD;
    logic [1:0]   sel_ND_mux;
    logic         sel_K_mux;
    logic         busy;
    logic [W-1:0] q;
    logic         q_valid;

    goldschmidt_ctrl #(.WIDTH(W), .ITERS(ITERS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .n_in       (n_in),
        .d_in       (d_in),
        .ia_in      (ia_in),
        .result     (result),
        .N          (N),
        .D          (D),
        .IA         (IA),
        .load_regN  (load_regN),
        .load_regD  (load_regD),
        .sel_ND_mux (sel_ND_mux),
        .sel_K_mux  (sel_K_mux),
        .busy       (busy),
        .q          (q),
        .q_valid    (q_valid)
    );

    always #5 clk = ~clk;

    // The datapath result is a distinct value in every cycle, so capturing
    // in the wrong cycle yields the wrong quotient.
    int edge_cnt = 0;
    function automatic logic [W-1:0] res_of(input int k);
        return W'(k * 40503 + 4660);
    endfunction
    assign result = res_of(edge_cnt);

    int assert_cnt = 0;
    int fail_cnt   = 0;

    // Reference state
    int           mcnt = 0;          // 0 = idle, else cycle index since accept
    logic         exp_valid = 1'b0;
    logic [W-1:0] m_n = '0, m_d = '0, m_ia = '0, m_q = '0;
    logic [W-1:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        assert_cnt++;
        assert (obs === exp_v) else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // {sel_ND_mux, sel_K_mux, load_regN, load_regD} expected at cycle m
    function automatic logic [4:0] exp_ctrl(input int m);
        if (m == 1) return 5'b00_1_0_1;
        if (m == 2) return 5'b01_1_1_0;
        if (m >= 3 && m <= 2 + 2 * ITERS) return (m % 2 == 1) ? 5'b10_0_0_1 : 5'b11_0_1_0;
        return 5'b00_0_0_0;
    endfunction

    // Advance one clock with the currently driven inputs, then check outputs
    // at the following falling edge.
    task automatic cyc();
        logic [W-1:0] popped;
        if (reset) begin
            mcnt = 0; exp_valid = 1'b0;
            m_n = '0; m_d = '0; m_ia = '0; m_q = '0;
            sb_q.delete();
        end else if (mcnt == 0 && start) begin
            mcnt = 1; exp_valid = 1'b0;
            m_n = n_in; m_d = d_in; m_ia = ia_in;
            // Result is sampled during CAPTURE, the cycle after edge a+LAST-1.
            sb_q.push_back(res_of(edge_cnt + 1 + LAST - 1));
        end else if (mcnt == LAST) begin
            mcnt = 0; exp_valid = 1'b1;
        end else if (mcnt > 0) begin
            mcnt++; exp_valid = 1'b0;
        end else begin
            exp_valid = 1'b0;
        end

        @(posedge clk);
        #1 edge_cnt++;
        @(negedge clk);

        if (exp_valid) begin
            if (sb_q.size() > 0) begin
                popped = sb_q.pop_front();
                m_q = popped;
            end else begin
                chk("scoreboard_underflow", 32'd1, 32'd0);
            end
        end
        $display("edge %0d: mcnt=%0d busy=%b ctrl=%b q_valid=%b q=%h N=%h D=%h IA=%h",
                 edge_cnt, mcnt, busy, {sel_ND_mux, sel_K_mux, load_regN, load_regD},
                 q_valid, q, N, D, IA);
        chk("busy",    32'(busy),    32'(mcnt != 0));
        chk("ctrl",    32'({sel_ND_mux, sel_K_mux, load_regN, load_regD}), 32'(exp_ctrl(mcnt)));
        chk("q_valid", 32'(q_valid), 32'(exp_valid));
        chk("q",       32'(q),       32'(m_q));
        chk("N",       32'(N),       32'(m_n));
        chk("D",       32'(D),       32'(m_d));
        chk("IA",      32'(IA),      32'(m_ia));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        reset = 1'b1; start = 1'b1;
        n_in = 16'hC000; d_in = 16'hA000; ia_in = 16'hA000;
        @(negedge clk);

        // Reset held with start high: nothing accepted, all outputs zero
        run(3);

        // Basic schedule with the reference operands
        reset = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        run(LAST + 2);

        // Start pulsed mid-operation with new operands must be ignored
        start = 1'b1; n_in = 16'h1234; d_in = 16'h5678; ia_in = 16'h9ABC;
        cyc();
        start = 1'b0;
        run(4);
        start = 1'b1; n_in = 16'hFFFF; d_in = 16'h0001; ia_in = 16'h8000;
        cyc();
        start = 1'b0;
        run(LAST);

        // Back-to-back: start held high, operands change every cycle
        start = 1'b1;
        for (int i = 0; i < 3 * (LAST + 1) + 2; i++) begin
            n_in = W'($urandom); d_in = W'($urandom); ia_in = W'($urandom);
            cyc();
        end
        start = 1'b0;
        run(LAST + 1);

        // Reset in cycle 6 of a request: aborted with no q_valid
        start = 1'b1; n_in = 16'h4444; d_in = 16'h5555; ia_in = 16'h6666;
        cyc();
        start = 1'b0;
        run(5);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        run(3);
        start = 1'b1; n_in = 16'hC000; d_in = 16'hA000; ia_in = 16'hA000;
        cyc();
        start = 1'b0;
        run(LAST + 2);

        // Reset and start together: request dropped
        reset = 1'b1; start = 1'b1;
        cyc();
        reset = 1'b0; start = 1'b0;
        run(2);

        // Random start pattern
        for (int i = 0; i < 80; i++) begin
            start = ($urandom_range(0, 3) == 0);
            n_in = W'($urandom); d_in = W'($urandom); ia_in = W'($urandom);
            cyc();
        end
        start = 1'b0;
        run(LAST + 2);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule : tb_goldschmidt_ctrl
